// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and GF(2^8) helpers for the inverse cipher
package aes_pkg;
    typedef logic [127:0] state_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            r = b[i] ? r ^ p : r;
            p = gf_xtime(p);
        end
        return r;
    endfunction

    // byte n sits at bits [127-8n -: 8], n = row + 4*col; row r rotates right by r
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c-r+4)%4))) +: 8];
        return o;
    endfunction

    // circulant 0e,0b,0d,09; first byte of the column is the MSB
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [31:0] m;
        logic [31:0] o;
        m = 32'h0e0b0d09;
        o = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                o[8*(3-i) +: 8] = o[8*(3-i) +: 8] ^ gf_mul(m[8*(3-((j-i)&3)) +: 8], a[8*(3-j) +: 8]);
        return o;
    endfunction
endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: key-load port plus ciphertext/plaintext valid-ready streams
interface aes_inv_cipher_iter_if #(parameter int KIDX_W = 4);
    import aes_pkg::*;
    logic              key_we;
    logic [KIDX_W-1:0] key_idx;
    state_t            key_wdata;
    logic              key_err;
    logic              in_valid;
    logic              in_ready;
    state_t            in_data;
    logic              out_valid;
    logic              out_ready;
    state_t            out_data;
    logic              busy;
    modport master (output key_we, key_idx, key_wdata, in_valid, in_data, out_ready,
                    input  key_err, in_ready, out_valid, out_data, busy);
    modport slave  (input  key_we, key_idx, key_wdata, in_valid, in_data, out_ready,
                    output key_err, in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; is_final skips InvMixColumns
module aes_inv_round import aes_pkg::*; (
    input  state_t state,
    input  state_t rk,
    input  logic   is_final,
    output state_t result
);
    state_t sr, sb, ark, mc;
    assign sr = inv_shift_rows(state);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        invsbox u_sb (.a(sr[8*i +: 8]), .y(sb[8*i +: 8]));
    end
    assign ark = sb ^ rk;
    // each 32-bit slice is one column with its first byte at the MSB
    always_comb begin
        for (int c = 0; c < 4; c++) mc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
    end
    assign result = is_final ? ark : mc;
endmodule

// File: rtl/invsbox.sv
// invsbox: AES inverse S-box as inverse affine map followed by GF(2^8) inversion
module invsbox import aes_pkg::*; (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] b, p, r;
    // inverse affine, then b^254 by square-and-multiply (0 maps to 0)
    always_comb begin
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        p = b;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        y = r;
    end
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES InvCipher, one round per clock, run-time round-key table
module aes_inv_cipher_iter import aes_pkg::*; #(
    parameter int NR     = AES_NR_128,
    parameter int KIDX_W = 4
) (
    input logic clk,
    input logic rst_n,
    aes_inv_cipher_iter_if.slave bus
);
    if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_bad_nr
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end
    if ((2 ** KIDX_W) < NR + 1) begin : g_bad_kidx
        $error("aes_inv_cipher_iter: KIDX_W too small for NR+1 round keys");
    end

    fsm_t              st;
    logic [KIDX_W-1:0] rnd;
    state_t            state, round_out;
    state_t            rk [0:NR];
    logic              key_ok, in_ready, out_valid, busy, key_err;

    assign key_ok        = (st == IDLE) && (bus.key_idx <= KIDX_W'(NR));
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = state;
    assign bus.busy      = busy;
    assign bus.key_err   = key_err;

    aes_inv_round u_round (
        .state    (state),
        .rk       (rk[rnd]),
        .is_final (st == FINAL),
        .result   (round_out)
    );

    // round-key table survives reset; writes only land while idle and in range
    always_ff @(posedge clk) begin
        if (bus.key_we && key_ok) rk[bus.key_idx] <= bus.key_wdata;
    end

    // control FSM with registered handshake outputs; rnd counts NR-1 down to 0 and stops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            rnd       <= '0;
            state     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            key_err   <= 1'b0;
        end else begin
            key_err <= bus.key_we && !key_ok;
            case (st)
                IDLE: if (bus.in_valid) begin
                    state    <= bus.in_data ^ rk[NR];
                    rnd      <= KIDX_W'(NR - 1);
                    st       <= ROUND;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                ROUND: begin
                    state <= round_out;
                    rnd   <= (rnd == '0) ? rnd : rnd - 1'b1;
                    if (rnd == KIDX_W'(1)) st <= FINAL;
                end
                FINAL: begin
                    state     <= round_out;
                    st        <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    st        <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
